uart_rx_param: RTL

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Samples

---
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with one-word valid/ready holder; parity stage enabled by UART_RX_PARITY_EN
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_clk,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    // Reject parameter sets the datapath widths were not sized for
    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx_param: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                 state;
    logic                   sync_meta;
    logic                   rxs;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   frame_flag;
    logic                   mid_bit;
    logic                   commit;
    logic                   commit_frame;
    logic                   commit_par;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad;
`endif

    // Two-flop synchroniser for the asynchronous line; resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= in;
            rxs       <= sync_meta;
        end
    end

    // Commit fires on the tick that takes the last stop sample; that sample is folded into the frame flag here
    always_comb begin
        mid_bit      = (tick_cnt == TICK_LAST);
        commit       = enable_clk && (state == S_STOP) && mid_bit && (bit_cnt == STOP_LAST);
        commit_frame = frame_flag | ~rxs;
`ifdef UART_RX_PARITY_EN
        commit_par   = par_bad;
`else
        commit_par   = 1'b0;
`endif
    end

    // Frame FSM: start validation, mid-bit data/parity/stop sampling; frozen when enable_clk is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            frame_flag <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else if (enable_clk) begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (mid_bit) begin
                        tick_cnt <= '0;
                        shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt    <= '0;
                            frame_flag <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state      <= S_PARITY;
`else
                            state      <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (mid_bit) begin
                        tick_cnt <= '0;
                        par_bad  <= ((^{shreg, rxs}) != PARITY_ODD[0]);
                        state    <= S_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (mid_bit) begin
                        tick_cnt <= '0;
                        if (!rxs) frame_flag <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-word holding register: load on commit when free or being drained, else drop and pulse overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ready) begin
                    data_out   <= shreg;
                    frame_err  <= commit_frame;
                    parity_err <= commit_par;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
